// File: rtl/axis_i2c_slave_if.sv
// AXI-Stream pair of the I2C target: m_* carries received write bytes out, s_* brings read bytes in.
// Handshake: a beat transfers on a rising clk edge where tvalid && tready; the source keeps tdata stable and tvalid high until then.
interface axis_i2c_slave_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;

  modport slave (
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready
  );

  modport master (
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready
  );
endinterface

// File: rtl/axis_i2c_slave.sv
// I2C target with oversampled SCL/SDA: write bytes leave on m_axis, read bytes arrive on s_axis.
// Open-drain SDA only, no clock stretching; state_o exposes the FSM state for observation.
module axis_i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DATA_WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  output logic             busy_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic [2:0]       state_o,
  axis_i2c_slave_if.slave  axis
);
  localparam int SW = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
  localparam int CW = $clog2(SW + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;

  logic [1:0]            scl_sync_q, sda_sync_q;
  logic                  scl_prev_q, sda_prev_q;
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-2:0]         shift_q, shift_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  rw_q, rw_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  s_tready;
  logic                  do_load;

  logic                  scl_s, sda_s;
  logic                  scl_rise, scl_fall, scl_high;
  logic                  start_c, stop_c;
  logic [SW-1:0]         shift_in;
  logic [DATA_WIDTH-1:0] load_byte;
  logic                  m_room;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign scl_high  = scl_s & scl_prev_q;
  assign start_c   = scl_high & sda_prev_q & ~sda_s;
  assign stop_c    = scl_high & ~sda_prev_q & sda_s;
  assign shift_in  = {shift_q, sda_s};
  // An empty source is answered with all-ones, which reads as a released bus.
  assign load_byte = axis.s_axis_tvalid ? axis.s_axis_tdata : '1;
  assign m_room    = !m_tvalid_q || axis.m_axis_tready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q && !axis.m_axis_tready;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    s_tready   = 1'b0;
    do_load    = 1'b0;

    if (start_c) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_c) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d = shift_in[SW-2:0];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(7)) begin
              cnt_d = '0;
              if (shift_in[7:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = shift_in[0];
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end
        end
        // The ACK slot opens on the first fall (SDA not yet driven) and closes on the second.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              do_load = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_DATA;
              cnt_d    = '0;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d = shift_in[SW-2:0];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
              cnt_d = '0;
              if (m_room) begin
                m_tdata_d  = shift_in[DATA_WIDTH-1:0];
                m_tvalid_d = 1'b1;
                state_d    = WR_ACK;
              end else begin
                ovf_d   = 1'b1;
                state_d = WAIT_STOP;
              end
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_DATA;
              cnt_d    = '0;
            end
          end
        end
        // cnt_q counts bits already placed on SDA; bit 7 went out with the load.
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == CW'(DATA_WIDTH)) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
              cnt_d    = '0;
            end else begin
              sda_oe_d = ~tx_q[DATA_WIDTH-1];
              tx_d     = {tx_q[DATA_WIDTH-2:0], 1'b0};
              cnt_d    = cnt_q + CW'(1);
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = WAIT_STOP;
            else       cnt_d   = CW'(1);
          end else if (scl_fall && cnt_q == CW'(1)) begin
            do_load = 1'b1;
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default:   state_d  = IDLE;
      endcase

      if (do_load) begin
        s_tready = axis.s_axis_tvalid;
        unf_d    = !axis.s_axis_tvalid;
        sda_oe_d = ~load_byte[DATA_WIDTH-1];
        tx_d     = {load_byte[DATA_WIDTH-2:0], 1'b0};
        cnt_d    = CW'(1);
        state_d  = RD_DATA;
      end
    end
  end

  assign sda_oe_o           = sda_oe_q;
  assign busy_o             = busy_q;
  assign overflow_o         = ovf_q;
  assign underflow_o        = unf_q;
  assign state_o            = state_q;
  assign axis.m_axis_tdata  = m_tdata_q;
  assign axis.m_axis_tvalid = m_tvalid_q;
  assign axis.s_axis_tready = s_tready;
endmodule

// File: tb/tb_axis_i2c_slave.sv
// Bench for axis_i2c_slave: bit-banged I2C master, AXIS sink/source, table vectors, hand sequences, random model.
module tb_axis_i2c_slave;
  localparam int         DW = 8;
  localparam int         Q  = 6;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, ovf, unf;
  logic [2:0] state;

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  axis_i2c_slave_if #(.DATA_WIDTH(DW)) axis ();

  axis_i2c_slave #(.SLAVE_ADDR(7'h50), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe_o(sda_oe), .busy_o(busy), .overflow_o(ovf), .underflow_o(unf),
    .state_o(state), .axis(axis)
  );

  // AXIS sink / source and event counters, sampled on the falling edge
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] src_q[$];
  int  src_rd = 0;
  int  ovf_cnt = 0, unf_cnt = 0, rdy_cnt = 0, oe_cnt = 0;
  bit  pend = 0;
  bit  hs;

  always @(negedge clk) begin
    hs = axis.s_axis_tready && axis.s_axis_tvalid;
    if (axis.m_axis_tvalid && axis.m_axis_tready) got_q.push_back(axis.m_axis_tdata);
    if (ovf) ovf_cnt++;
    if (unf) unf_cnt++;
    if (axis.s_axis_tready) rdy_cnt++;
    if (sda_oe) oe_cnt++;
    if (pend) begin
      src_rd++;
      pend = 0;
    end
    if (hs) begin
      pend = 1;
    end else begin
      axis.s_axis_tvalid = (src_rd < src_q.size());
      axis.s_axis_tdata  = (src_rd < src_q.size()) ? src_q[src_rd] : '0;
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_bit(input logic b, output logic rb);
    sda_m = b;     wait_clk(Q);
    scl_m = 1'b1;  wait_clk(Q);
    rb = sda_line; wait_clk(Q);
    scl_m = 1'b0;  wait_clk(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    sda_m = 1'b0; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop(output int n_busy);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    sda_m = 1'b1;
    n_busy = 0;
    for (int i = 1; i <= 2 * Q; i++) begin
      wait_clk(1);
      if (!busy && n_busy == 0) n_busy = i;
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic acked);
    logic rb;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], rb);
    bus_bit(1'b1, rb);
    acked = !rb;
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] b);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, rb);
      b[i] = rb;
    end
    bus_bit(!ack, rb);
  endtask

  // scoreboard
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic [2:0] exp_ack;
    int         exp_out;
    int         exp_ovf;
    bit         exp_silent;
    int         exp_nbusy;
  } wr_vec_t;

  wr_vec_t       vecs[5];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl_src[$];
  logic [DW-1:0] wr_bytes[$];
  logic [7:0]    b, rbyte;
  logic          a0, a1, a2, rb;
  int            nb, base_got, base_ovf, base_unf, base_rdy, base_oe;
  int            kind, n, navail, n_unf;
  logic [6:0]    raddr;

  initial begin
    axis.m_axis_tready = 1'b1;
    vecs[0] = '{8'hA0, 8'h3C, 8'h5A, 1'b1, 3'b111, 2, 0, 1'b0, 3};
    vecs[1] = '{8'hA2, 8'h11, 8'h22, 1'b1, 3'b000, 0, 0, 1'b1, 1};
    vecs[2] = '{8'hA0, 8'h96, 8'h69, 1'b0, 3'b110, 1, 1, 1'b0, 3};
    vecs[3] = '{8'h20, 8'hA0, 8'hA1, 1'b1, 3'b000, 0, 0, 1'b1, 1};
    vecs[4] = '{8'hA0, 8'hFF, 8'h00, 1'b1, 3'b111, 2, 0, 1'b0, 3};

    wait_clk(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_tvalid", axis.m_axis_tvalid, 0);
    check("rst_tdata", axis.m_axis_tdata, 0);
    check("rst_s_tready", axis.s_axis_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf_unf", {ovf, unf}, 0);
    check("rst_state", state, ST_IDLE);
    rst = 1'b0;
    wait_clk(5);

    // table-driven write frames: address byte plus two data bytes
    for (int v = 0; v < 5; v++) begin
      base_got = got_q.size();
      base_ovf = ovf_cnt;
      base_oe  = oe_cnt;
      axis.m_axis_tready = vecs[v].rdy;
      bus_start();
      wr_byte(vecs[v].addr, a0);
      wr_byte(vecs[v].d0, a1);
      wr_byte(vecs[v].d1, a2);
      bus_stop(nb);
      check($sformatf("v%0d_acks", v), {a0, a1, a2}, vecs[v].exp_ack);
      check($sformatf("v%0d_ovf", v), ovf_cnt - base_ovf, vecs[v].exp_ovf);
      check($sformatf("v%0d_busy_fall", v), nb, vecs[v].exp_nbusy);
      check($sformatf("v%0d_state", v), state, ST_IDLE);
      if (vecs[v].exp_silent) check($sformatf("v%0d_silent", v), oe_cnt - base_oe, 0);
      if (!vecs[v].rdy) begin
        check($sformatf("v%0d_held_valid", v), axis.m_axis_tvalid, 1);
        check($sformatf("v%0d_held_data", v), axis.m_axis_tdata, vecs[v].d0);
        axis.m_axis_tready = 1'b1;
        wait_clk(3);
      end
      check($sformatf("v%0d_out_count", v), got_q.size() - base_got, vecs[v].exp_out);
      for (int k = 0; k < vecs[v].exp_out && base_got + k < got_q.size(); k++)
        check($sformatf("v%0d_out%0d", v, k), got_q[base_got + k], (k == 0) ? vecs[v].d0 : vecs[v].d1);
    end

    // read of two supplied bytes, ACK then NACK
    base_rdy = rdy_cnt;
    base_got = got_q.size();
    src_q.push_back(8'hC3);
    src_q.push_back(8'h7E);
    bus_start();
    wr_byte(8'hA1, a0);
    check("rd_addr_ack", a0, 1);
    rd_byte(1'b1, rbyte);
    check("rd_byte0", rbyte, 8'hC3);
    rd_byte(1'b0, rbyte);
    check("rd_byte1", rbyte, 8'h7E);
    check("rd_busy", busy, 1);
    check("rd_wait_stop", state, ST_WAIT_STOP);
    check("rd_tready_pulses", rdy_cnt - base_rdy, 2);
    check("rd_no_m_axis", got_q.size() - base_got, 0);
    bus_stop(nb);
    check("rd_idle", state, ST_IDLE);

    // read with nothing available
    base_unf = unf_cnt;
    base_rdy = rdy_cnt;
    bus_start();
    wr_byte(8'hA1, a0);
    rd_byte(1'b0, rbyte);
    bus_stop(nb);
    check("unf_byte", rbyte, 8'hFF);
    check("unf_pulse", unf_cnt - base_unf, 1);
    check("unf_no_tready", rdy_cnt - base_rdy, 0);

    // repeated START four bits into a write byte, then a read
    base_got = got_q.size();
    src_q.push_back(8'h5C);
    bus_start();
    wr_byte(8'hA0, a0);
    check("rs_wr_addr_ack", a0, 1);
    bus_bit(1'b1, rb);
    bus_bit(1'b0, rb);
    bus_bit(1'b1, rb);
    bus_bit(1'b0, rb);
    bus_start();
    wr_byte(8'hA1, a0);
    check("rs_rd_addr_ack", a0, 1);
    rd_byte(1'b0, rbyte);
    check("rs_rd_byte", rbyte, 8'h5C);
    bus_stop(nb);
    check("rs_no_m_axis", got_q.size() - base_got, 0);

    // reset in the middle of a read byte while SDA is pulled low
    src_q.push_back(8'h00);
    bus_start();
    wr_byte(8'hA1, a0);
    bus_bit(1'b1, rb);
    bus_bit(1'b1, rb);
    check("mid_bit6", rb, 0);
    check("mid_driving", sda_oe, 1);
    rst = 1'b1;
    wait_clk(1);
    check("mid_rst_oe", sda_oe, 0);
    check("mid_rst_state", state, ST_IDLE);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    wait_clk(2);
    bus_stop(nb);
    base_got = got_q.size();
    bus_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'h77, a1);
    bus_stop(nb);
    check("post_rst_acks", {a0, a1}, 2'b11);
    check("post_rst_count", got_q.size() - base_got, 1);
    if (got_q.size() > base_got) check("post_rst_byte", got_q[base_got], 8'h77);

    // randomized frames against a queue-level model
    axis.m_axis_tready = 1'b1;
    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 3);
      exp_q.delete();
      base_got = got_q.size();
      base_unf = unf_cnt;
      base_rdy = rdy_cnt;
      base_oe  = oe_cnt;
      if (kind == 0) begin
        wr_bytes.delete();
        for (int k = 0; k < n; k++) wr_bytes.push_back(DW'($urandom_range(0, 255)));
        exp_q = wr_bytes;
        bus_start();
        wr_byte({7'h50, 1'b0}, a0);
        check($sformatf("r%0d_wr_addr_ack", t), a0, 1);
        for (int k = 0; k < n; k++) begin
          wr_byte(wr_bytes[k], a1);
          check($sformatf("r%0d_wr_ack%0d", t, k), a1, 1);
        end
        bus_stop(nb);
        check($sformatf("r%0d_wr_count", t), got_q.size() - base_got, exp_q.size());
        for (int k = 0; k < exp_q.size() && base_got + k < got_q.size(); k++)
          check($sformatf("r%0d_wr_byte%0d", t, k), got_q[base_got + k], exp_q[k]);
      end else if (kind == 1) begin
        navail = $urandom_range(0, 3);
        for (int k = 0; k < navail; k++) begin
          b = 8'($urandom_range(0, 255));
          src_q.push_back(b);
          mdl_src.push_back(b);
        end
        n_unf = 0;
        for (int k = 0; k < n; k++) begin
          if (mdl_src.size() > 0) exp_q.push_back(mdl_src.pop_front());
          else begin
            exp_q.push_back(8'hFF);
            n_unf++;
          end
        end
        bus_start();
        wr_byte({7'h50, 1'b1}, a0);
        check($sformatf("r%0d_rd_addr_ack", t), a0, 1);
        for (int k = 0; k < n; k++) begin
          rd_byte(k < n - 1, rbyte);
          check($sformatf("r%0d_rd_byte%0d", t, k), rbyte, exp_q[k]);
        end
        bus_stop(nb);
        check($sformatf("r%0d_rd_unf", t), unf_cnt - base_unf, n_unf);
        check($sformatf("r%0d_rd_tready", t), rdy_cnt - base_rdy, n - n_unf);
      end else begin
        raddr = 7'($urandom_range(0, 127));
        if (raddr == 7'h50) raddr = 7'h51;
        bus_start();
        wr_byte({raddr, 1'($urandom_range(0, 1))}, a0);
        wr_byte(8'($urandom_range(0, 255)), a1);
        bus_stop(nb);
        check($sformatf("r%0d_mm_acks", t), {a0, a1}, 2'b00);
        check($sformatf("r%0d_mm_silent", t), oe_cnt - base_oe, 0);
        check($sformatf("r%0d_mm_no_axis", t), (got_q.size() - base_got) + (rdy_cnt - base_rdy), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end
endmodule
